decoder_nto2n_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable, and the successor to the team's combinational 2-to-4 decoder.
- Direct mode: decodes the `sel` input each cycle.
- Scan mode: walks the one-hot output through all 2^N positions itself, holding each position for a programmable dwell time.
- Used as a digit/row select for multiplexed 7-segment and LED-matrix drivers, and as a generic registered decoder elsewhere.

---
 rtl/decoder_nto2n_scan.sv | 147 ++++++++++++++
 tb/tb_decoder_nto2n_scan.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_scan.sv
// decoder_nto2n_scan
//   Registered N-to-2^N one-hot decoder with enable. It has two modes:
//   direct decode of sel, and auto-scan. In auto-scan the one-hot output
//   walks through every position by itself and holds each one for DWELL
//   cycles. Typical use is digit/row select for multiplexed displays.
//
//   Optional build macro: DECODER_SCAN_BLANK_EN
//     When defined, a one-cycle all-zero BLANK slot is inserted before each
//     scan advance. This is anti-ghosting for multiplexed displays, and it
//     makes each position last DWELL+1 cycles.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active low
//   en     in   enable; low drives out/idx/step/wrap to zero
//   mode   in   0 = direct decode, 1 = auto-scan
//   sel    in   [SEL_W-1:0] select index (direct mode only)
//   out    out  [OUT_W-1:0] registered one-hot output, zero when disabled
//   idx    out  [SEL_W-1:0] registered index currently shown on out
//   step   out  pulse on the first cycle of a new scan position
//   wrap   out  pulse together with step when idx returns to 0
//
// States
//   state    | meaning
//   S_IDLE   | en=0, all outputs zero
//   S_DIRECT | en=1, mode=0, out follows sel
//   S_SCAN   | en=1, mode=1, dwell counter running
//   S_BLANK  | one blank cycle between scan positions (macro builds only)
module decoder_nto2n_scan #(
  parameter  int SEL_W = 2,
  parameter  int DWELL = 4,
  localparam int OUT_W = 1 << SEL_W,
  localparam int CNT_W = (DWELL <= 2) ? 1 : $clog2(DWELL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             step,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2
`ifdef DECODER_SCAN_BLANK_EN
    ,S_BLANK = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q,   out_d;
  logic [SEL_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             step_q,  step_d;
  logic             wrap_q,  wrap_d;
  logic [SEL_W-1:0] nxt_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    // The increment wraps naturally at SEL_W bits.
    nxt_idx = idx_q + SEL_W'(1);

    if (!en) begin
      state_d = S_IDLE;
      out_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = S_DIRECT;
      out_d   = OUT_W'(1) << sel;
      idx_d   = sel;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (cnt_q == DWELL_M1) begin
            cnt_d = '0;
`ifdef DECODER_SCAN_BLANK_EN
            state_d = S_BLANK;
            out_d   = '0;
`else
            idx_d  = nxt_idx;
            out_d  = OUT_W'(1) << nxt_idx;
            step_d = 1'b1;
            wrap_d = (nxt_idx == '0);
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef DECODER_SCAN_BLANK_EN
        S_BLANK: begin
          state_d = S_SCAN;
          cnt_d   = '0;
          idx_d   = nxt_idx;
          out_d   = OUT_W'(1) << nxt_idx;
          step_d  = 1'b1;
          wrap_d  = (nxt_idx == '0);
        end
`endif
        default: begin
          // Entry from IDLE or DIRECT always restarts the scan at position 0.
          state_d = S_SCAN;
          out_d   = OUT_W'(1);
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
module tb_decoder_nto2n_scan;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif
  localparam int D2 = 3;
  localparam int P2 = D2 + BLANK;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] i;
    logic       s;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en2, mode2, en3, mode3;
  logic [1:0] sel2;
  logic [2:0] sel3;
  logic [3:0] out2;
  logic [1:0] idx2;
  logic       step2, wrap2;
  logic [7:0] out3;
  logic [2:0] idx3;
  logic       step3, wrap3;

  int   errors = 0;
  int   checks = 0;
  exp_t q2[$];
  exp_t q3[$];
  bit   m2_scan, m3_scan;
  int   m2_pos, m3_pos;

  always #5 clk = ~clk;

  decoder_nto2n_scan #(.SEL_W(2), .DWELL(D2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .sel(sel2),
    .out(out2), .idx(idx2), .step(step2), .wrap(wrap2)
  );

  decoder_nto2n_scan #(.SEL_W(3), .DWELL(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .sel(sel3),
    .out(out3), .idx(idx3), .step(step3), .wrap(wrap3)
  );

  // Reference model. In scan mode the state is just the number of cycles
  // since scan entry. Position and phase are derived from that count by
  // division, not from a dwell counter.
  task automatic model_step(input logic rn, input logic e, input logic m, input int s,
                            input int n, input int dwell, inout bit scan, inout int pos,
                            output exp_t x);
    int p, k, o;
    x = '0;
    if (!rn || !e) begin
      scan = 1'b0;
    end else if (!m) begin
      scan = 1'b0;
      x.o  = 8'(1 << s);
      x.i  = 3'(s);
    end else begin
      if (!scan) begin
        scan = 1'b1;
        pos  = 0;
      end else begin
        pos++;
      end
      p   = dwell + BLANK;
      k   = (pos / p) % (1 << n);
      o   = pos % p;
      x.i = 3'(k);
      x.o = (BLANK == 1 && o == p - 1) ? 8'h00 : 8'(1 << k);
      x.s = (o == 0 && pos > 0);
      x.w = x.s && (k == 0);
    end
  endtask

  // Predict the result of the coming edge for both DUTs, then advance to
  // the sample point.
  task automatic tick();
    exp_t e2, e3;
    model_step(rst_n, en2, mode2, int'(sel2), 2, D2, m2_scan, m2_pos, e2);
    model_step(rst_n, en3, mode3, int'(sel3), 3, 1, m3_scan, m3_pos, e3);
    q2.push_back(e2);
    q3.push_back(e3);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x2, x3;
    rst_n = 1'b0; en2 = 1'b1; mode2 = 1'b0; sel2 = 2'b10;
    en3 = 1'b0; mode3 = 1'b0; sel3 = 3'd0;
    repeat (2) begin
      tick();
      x2 = q2.pop_front(); x3 = q3.pop_front();
      checks++;
      if (out2 !== 4'b0000 || idx2 !== 2'd0 || step2 !== 1'b0 || wrap2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: out=%b idx=%0d step=%b wrap=%b, want 0000/0/0/0", out2, idx2, step2, wrap2);
      end
      checks++;
      if ({out3, idx3, step3, wrap3} !== x3) begin
        errors++;
        $display("FAIL reset_dut3: got %h want %h", {out3, idx3, step3, wrap3}, x3);
      end
    end
    rst_n = 1'b1;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0100 || idx2 !== 2'd2 || step2 !== 1'b0 || wrap2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out=%b idx=%0d step=%b wrap=%b, want 0100/2/0/0", out2, idx2, step2, wrap2);
    end
    checks++;
    if ({4'b0, out2, 1'b0, idx2, step2, wrap2} !== x2) begin
      errors++;
      $display("FAIL reset_sb: got %h want %h", {4'b0, out2, 1'b0, idx2, step2, wrap2}, x2);
    end
  endtask

  task automatic test_enable();
    exp_t x2, x3;
    sel2 = 2'b11;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    en2 = 1'b0;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0000 || idx2 !== 2'd0) begin
      errors++;
      $display("FAIL en_low: out=%b idx=%0d, want 0000/0", out2, idx2);
    end
    en2 = 1'b1;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b1000 || idx2 !== 2'd3) begin
      errors++;
      $display("FAIL en_return: out=%b idx=%0d, want 1000/3", out2, idx2);
    end
    checks++;
    if ({4'b0, out2, 1'b0, idx2, step2, wrap2} !== x2) begin
      errors++;
      $display("FAIL en_sb: got %h want %h", {4'b0, out2, 1'b0, idx2, step2, wrap2}, x2);
    end
  endtask

  task automatic test_scan();
    exp_t x2, x3;
    int   nstep, nwrap;
    nstep = 0; nwrap = 0;
    en2 = 1'b0;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    en2 = 1'b1; mode2 = 1'b1;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0001 || idx2 !== 2'd0 || step2 !== 1'b0 || wrap2 !== 1'b0) begin
      errors++;
      $display("FAIL scan_entry: out=%b idx=%0d step=%b wrap=%b, want 0001/0/0/0", out2, idx2, step2, wrap2);
    end
    for (int c = 1; c <= 4 * P2; c++) begin
      tick();
      x2 = q2.pop_front(); x3 = q3.pop_front();
      nstep += int'(step2);
      nwrap += int'(wrap2);
      checks++;
      if ({4'b0, out2, 1'b0, idx2, step2, wrap2} !== x2) begin
        errors++;
        $display("FAIL scan_seq c=%0d: got out=%b idx=%0d step=%b wrap=%b want %h",
                 c, out2, idx2, step2, wrap2, x2);
      end
    end
    checks++;
    if (out2 !== 4'b0001 || wrap2 !== 1'b1) begin
      errors++;
      $display("FAIL scan_round_end: out=%b wrap=%b, want 0001/1", out2, wrap2);
    end
    checks++;
    if (nstep !== 4 || nwrap !== 1) begin
      errors++;
      $display("FAIL scan_pulses: steps=%0d wraps=%0d, want 4/1", nstep, nwrap);
    end
  endtask

  task automatic test_mode_switch();
    exp_t x2, x3;
    mode2 = 1'b0;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    mode2 = 1'b1;
    repeat (2 * P2 + 1) begin
      tick();
      x2 = q2.pop_front(); x3 = q3.pop_front();
    end
    checks++;
    if (idx2 !== 2'd2 || out2 !== 4'b0100) begin
      errors++;
      $display("FAIL mid_scan_pos: out=%b idx=%0d, want 0100/2", out2, idx2);
    end
    mode2 = 1'b0; sel2 = 2'd1;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0010 || idx2 !== 2'd1 || step2 !== 1'b0) begin
      errors++;
      $display("FAIL scan_to_direct: out=%b idx=%0d step=%b, want 0010/1/0", out2, idx2, step2);
    end
    mode2 = 1'b1;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0001 || idx2 !== 2'd0 || step2 !== 1'b0) begin
      errors++;
      $display("FAIL direct_to_scan: out=%b idx=%0d step=%b, want 0001/0/0", out2, idx2, step2);
    end
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    rst_n = 1'b0;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out2 !== 4'b0000 || idx2 !== 2'd0 || step2 !== 1'b0 || wrap2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: out=%b idx=%0d step=%b wrap=%b, want zeros", out2, idx2, step2, wrap2);
    end
    rst_n = 1'b1;
    en2 = 1'b0;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
  endtask

  task automatic test_width_dwell();
    exp_t x2, x3;
    int   nwrap;
    nwrap = 0;
    en3 = 1'b1; mode3 = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      tick();
      x2 = q2.pop_front(); x3 = q3.pop_front();
      nwrap += int'(wrap3);
      checks++;
      if ({out3, idx3, step3, wrap3} !== x3) begin
        errors++;
        $display("FAIL w8_scan c=%0d: got out=%h idx=%0d step=%b wrap=%b want %h",
                 c, out3, idx3, step3, wrap3, x3);
      end
    end
    checks++;
    if (nwrap !== 16 / (8 * (1 + BLANK))) begin
      errors++;
      $display("FAIL w8_wraps: got %0d want %0d", nwrap, 16 / (8 * (1 + BLANK)));
    end
    mode3 = 1'b0; sel3 = 3'd5;
    tick();
    x2 = q2.pop_front(); x3 = q3.pop_front();
    checks++;
    if (out3 !== 8'b0010_0000 || idx3 !== 3'd5) begin
      errors++;
      $display("FAIL w8_direct5: out=%b idx=%0d, want 00100000/5", out3, idx3);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x2, x3;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en2   = ($urandom_range(0, 15) != 0);
      en3   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) mode2 = ~mode2;
      if ($urandom_range(0, 11) == 0) mode3 = ~mode3;
      sel2 = 2'($urandom);
      sel3 = 3'($urandom);
      tick();
      x2 = q2.pop_front(); x3 = q3.pop_front();
      checks++;
      if ({4'b0, out2, 1'b0, idx2, step2, wrap2} !== x2) begin
        errors++;
        $display("FAIL rand2 c=%0d: got %h want %h", c, {4'b0, out2, 1'b0, idx2, step2, wrap2}, x2);
      end
      checks++;
      if ({out3, idx3, step3, wrap3} !== x3) begin
        errors++;
        $display("FAIL rand3 c=%0d: got %h want %h", c, {out3, idx3, step3, wrap3}, x3);
      end
      checks++;
      if ($countones(out2) > 1 || $countones(out3) > 1) begin
        errors++;
        $display("FAIL onehot c=%0d: out2=%b out3=%b, want at most one bit", c, out2, out3);
      end
    end
  endtask

  initial begin
    m2_scan = 1'b0; m3_scan = 1'b0; m2_pos = 0; m3_pos = 0;
    @(negedge clk);
    test_reset();
    test_enable();
    test_scan();
    test_mode_switch();
    test_width_dwell();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
